// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser.
// Packets are five bytes long: sync, address, data high, data low, checksum.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DHI   = 3'd2,
        DLO   = 3'd3,
        CHK   = 3'd4,
        WRITE = 3'd5
    } cmd_state_t;

    localparam int unsigned PKT_LEN = 5;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled and flags expiry
// when TIMEOUT_CYCLES-1 is reached without a clear in the same cycle.
module uart_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 416_666
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic expired_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_in || !enable_in) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An arriving byte (clear) always beats expiry in the same cycle.
    assign expired_out = enable_in && !clear_in && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into 5-byte register-write packets with checksum,
// gap timeout and saturating error count; all outputs are registered.
//
// state | meaning
// IDLE  | waiting for sync byte, other bytes dropped
// ADDR  | waiting for address byte
// DHI   | waiting for data high byte
// DLO   | waiting for data low byte
// CHK   | waiting for checksum byte
// WRITE | one-cycle write strobe; incoming byte handled as in IDLE
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 416_666,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rx_valid_in,
    input  logic [7:0]               rx_byte_in,
    output logic                     wr_en_out,
    output logic [7:0]               wr_addr_out,
    output logic [15:0]              wr_data_out,
    output logic                     busy_out,
    output logic                     err_crc_out,
    output logic                     err_timeout_out,
    output logic [ERR_CNT_WIDTH-1:0] err_count_out
);

    cmd_state_t state_q, state_d;
    logic [7:0]  addr_q, addr_d, dhi_q, dhi_d, dlo_q, dlo_d, chk_q, chk_d;
    logic        wr_en_q, wr_en_d, busy_q, busy_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        err_crc_q, err_crc_d, err_to_q, err_to_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic        timed, expired;

    assign timed = (state_q == ADDR) || (state_q == DHI) ||
                   (state_q == DLO)  || (state_q == CHK);

    uart_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .clear_in    (rx_valid_in),
        .enable_in   (timed),
        .expired_out (expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dhi_d     = dhi_q;
        dlo_d     = dlo_q;
        chk_d     = chk_q;
        err_crc_d = 1'b0;
        err_to_d  = 1'b0;
        case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (rx_valid_in && (rx_byte_in == SYNC_BYTE)) begin
                    state_d = ADDR;
                    chk_d   = '0;
                end
            end
            ADDR, DHI, DLO: begin
                if (rx_valid_in) begin
                    chk_d = chk_q ^ rx_byte_in;
                    if (state_q == ADDR) begin
                        addr_d  = rx_byte_in;
                        state_d = DHI;
                    end else if (state_q == DHI) begin
                        dhi_d   = rx_byte_in;
                        state_d = DLO;
                    end else begin
                        dlo_d   = rx_byte_in;
                        state_d = CHK;
                    end
                end else if (expired) begin
                    state_d  = IDLE;
                    err_to_d = 1'b1;
                end
            end
            CHK: begin
                if (rx_valid_in) begin
                    if (rx_byte_in == chk_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d   = IDLE;
                        err_crc_d = 1'b1;
                    end
                end else if (expired) begin
                    state_d  = IDLE;
                    err_to_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_en_d   = (state_d == WRITE);
        busy_d    = (state_d != IDLE);
        wr_addr_d = wr_en_d ? addr_q : wr_addr_q;
        wr_data_d = wr_en_d ? {dhi_q, dlo_q} : wr_data_q;
        err_cnt_d = err_cnt_q;
        if ((err_crc_d || err_to_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            dhi_q     <= '0;
            dlo_q     <= '0;
            chk_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            err_crc_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dhi_q     <= dhi_d;
            dlo_q     <= dlo_d;
            chk_q     <= chk_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            err_crc_q <= err_crc_d;
            err_to_q  <= err_to_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign busy_out        = busy_q;
    assign err_crc_out     = err_crc_q;
    assign err_timeout_out = err_to_q;
    assign err_count_out   = err_cnt_q;

endmodule
